axis_fifo_wr_ctrl: RTL and testbench

- Write-side pointer and flag controller for the dual-clock AXIS data FIFO.
- Runs entirely in the write clock domain.
- Generates the write address and memory write enable, and publishes a Gray-coded write pointer for the read-domain bit synchronizer.
- Consumes the read pointer after it has been synchronized into this domain, and from it derives full, almost-full, fill level, overflow and a drain handshake.

---
 rtl/axis_fifo_wr_ctrl_pkg.sv | 27 ++
 rtl/axis_fifo_wr_ctrl_if.sv | 31 +++
 rtl/axis_fifo_wr_ctrl.sv | 108 ++++++++++
 tb/tb_axis_fifo_wr_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_wr_ctrl_pkg.sv
// Shared types and pointer-code helpers for the dual-clock AXIS FIFO.
// The helpers work on a fixed maximum width; callers cast to their pointer width.
package axis_fifo_pkg;

    localparam int unsigned CONV_W = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } wr_ctrl_state_e;

    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper bits leave the prefix-XOR of the low bits unaffected.
    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
        logic [CONV_W-1:0] b;
        b = g;
        for (int unsigned i = 1; i < CONV_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/axis_fifo_wr_ctrl_if.sv
// Write-side handshake, memory strobe and pointer/flag bundle of the AXIS FIFO.
interface axis_fifo_wr_ctrl_if #(
    parameter int unsigned AW = 4
);
    logic          wr_en;
    logic          wr_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [AW:0]   wr_ptr_gray;
    logic [AW:0]   rd_ptr_gray_sync;
    logic          full;
    logic          almost_full;
    logic [AW:0]   wr_count;
    logic          overflow;
    logic          overflow_clr;
    logic          drain_req;
    logic          drain_done;

    // The write controller is the AXIS slave of the upstream stream.
    modport slave (
        input  wr_en, rd_ptr_gray_sync, overflow_clr, drain_req,
        output wr_ready, mem_we, mem_waddr, wr_ptr_gray, full, almost_full,
               wr_count, overflow, drain_done
    );

    modport master (
        output wr_en, rd_ptr_gray_sync, overflow_clr, drain_req,
        input  wr_ready, mem_we, mem_waddr, wr_ptr_gray, full, almost_full,
               wr_count, overflow, drain_done
    );
endinterface

// File: rtl/axis_fifo_wr_ctrl.sv
// Write-domain pointer and flag controller of the dual-clock AXIS FIFO.
// Flags are registered from next-pointer values so rd_ptr_gray_sync never reaches an output combinationally.
module axis_fifo_wr_ctrl
    import axis_fifo_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned AF_MARGIN  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    axis_fifo_wr_ctrl_if.slave  bus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] AF_LEVEL = PW'(FIFO_DEPTH - AF_MARGIN);

    if ((FIFO_DEPTH < 4) || ((1 << AW) != FIFO_DEPTH) ||
        (AF_MARGIN < 1) || (AF_MARGIN > FIFO_DEPTH - 1)) begin : g_param_check
        $error("axis_fifo_wr_ctrl: illegal FIFO_DEPTH/AF_MARGIN");
    end

    wr_ctrl_state_e state_q, state_d;
    logic [PW-1:0]  wr_bin_q, wr_gray_q, cnt_q;
    logic           full_q, af_q, ovf_q, done_q;

    logic [PW-1:0]  rq, rd_bin, wr_bin_nxt, wr_gray_nxt, cnt_nxt;
    logic           full_nxt, af_nxt, ovf_d, done_d;
    logic           wr_ready_c, mem_we_c;

    assign wr_ready_c = !full_q && (state_q == RUN);
    assign mem_we_c   = bus.wr_en && wr_ready_c;

    // Next pointer values and the flags derived from them.
    always_comb begin
        rq          = bus.rd_ptr_gray_sync;
        rd_bin      = PW'(gray2bin(32'(rq)));
        wr_bin_nxt  = wr_bin_q + PW'(mem_we_c);
        wr_gray_nxt = PW'(bin2gray(32'(wr_bin_nxt)));
        full_nxt    = (wr_gray_nxt == {~rq[AW:AW-1], rq[AW-2:0]});
        cnt_nxt     = wr_bin_nxt - rd_bin;
        af_nxt      = (cnt_nxt >= AF_LEVEL);
    end

    // Sticky overflow; a fresh event beats a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (bus.wr_en && !wr_ready_c && (state_q == RUN)) begin
            ovf_d = 1'b1;
        end else if (bus.overflow_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Drain FSM next-state and pulse decode.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.drain_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (cnt_nxt == '0) state_d = DONE;
            end
            DONE: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_bin_q  <= wr_bin_nxt;
            wr_gray_q <= wr_gray_nxt;
            full_q    <= full_nxt;
            af_q      <= af_nxt;
            cnt_q     <= cnt_nxt;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign bus.wr_ready    = wr_ready_c;
    assign bus.mem_we      = mem_we_c;
    assign bus.mem_waddr   = wr_bin_q[AW-1:0];
    assign bus.wr_ptr_gray = wr_gray_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.wr_count    = cnt_q;
    assign bus.overflow    = ovf_q;
    assign bus.drain_done  = done_q;

endmodule

// File: tb/tb_axis_fifo_wr_ctrl.sv
// Directed bench for axis_fifo_wr_ctrl (FIFO_DEPTH=16, AF_MARGIN=2).
module tb_axis_fifo_wr_ctrl;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [4:0] w;
    logic [4:0] g_prev;

    axis_fifo_wr_ctrl_if #(.AW(4)) bus ();

    axis_fifo_wr_ctrl #(.FIFO_DEPTH(16), .AF_MARGIN(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] gray5(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_ptr_gray_sync = '0;
        bus.overflow_clr = 1'b0;
        bus.drain_req = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_gray", 32'(bus.wr_ptr_gray), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_af", 32'(bus.almost_full), 0);
        chk("rst_cnt", 32'(bus.wr_count), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_done", 32'(bus.drain_done), 0);
        chk("rst_ready", 32'(bus.wr_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fill 16 entries with the read pointer parked at 0.
        bus.wr_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            #1;
            chk("fill_we", 32'(bus.mem_we), 1);
            chk("fill_addr", 32'(bus.mem_waddr), 32'(k - 1));
            tick();
            chk("fill_cnt", 32'(bus.wr_count), 32'(k));
            chk("fill_af", 32'(bus.almost_full), (k >= 14) ? 1 : 0);
            chk("fill_full", 32'(bus.full), (k == 16) ? 1 : 0);
        end
        chk("fill_gray", 32'(bus.wr_ptr_gray), 32'h18);

        // Writes while full.
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("ovf_we", 32'(bus.mem_we), 0);
            tick();
            chk("ovf_gray", 32'(bus.wr_ptr_gray), 32'h18);
            chk("ovf_flag", 32'(bus.overflow), 1);
        end
        bus.overflow_clr = 1'b1;
        tick();
        chk("ovf_set_wins", 32'(bus.overflow), 1);
        bus.wr_en = 1'b0;
        tick();
        chk("ovf_cleared", 32'(bus.overflow), 0);
        bus.overflow_clr = 1'b0;

        // Release one slot.
        bus.rd_ptr_gray_sync = 5'b00001;
        tick();
        chk("rel_full", 32'(bus.full), 0);
        chk("rel_cnt", 32'(bus.wr_count), 15);
        chk("rel_ready", 32'(bus.wr_ready), 1);
        chk("rel_af", 32'(bus.almost_full), 1);

        // Stream 40 accepts with the read pointer trailing by 3.
        w = 5'd16;
        bus.rd_ptr_gray_sync = gray5(5'd13);
        tick();
        chk("wrap_pre_cnt", 32'(bus.wr_count), 3);
        bus.wr_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            g_prev = bus.wr_ptr_gray;
            bus.rd_ptr_gray_sync = gray5(w - 5'd2);
            #1;
            chk("wrap_addr", 32'(bus.mem_waddr), 32'(w[3:0]));
            tick();
            w = w + 5'd1;
            chk("wrap_1bit", $countones(g_prev ^ bus.wr_ptr_gray), 1);
            chk("wrap_gray", 32'(bus.wr_ptr_gray), 32'(gray5(w)));
            chk("wrap_cnt", 32'(bus.wr_count), 3);
            chk("wrap_full", 32'(bus.full), 0);
        end
        bus.wr_en = 1'b0;

        // Drain with 5 entries present.
        bus.rd_ptr_gray_sync = gray5(w - 5'd5);
        tick();
        chk("drn_cnt5", 32'(bus.wr_count), 5);
        bus.drain_req = 1'b1;
        tick();
        bus.drain_req = 1'b0;
        bus.wr_en = 1'b1;
        #1;
        chk("drn_ready", 32'(bus.wr_ready), 0);
        chk("drn_we", 32'(bus.mem_we), 0);
        tick();
        chk("drn_no_ovf", 32'(bus.overflow), 0);
        chk("drn_hold_cnt", 32'(bus.wr_count), 5);
        chk("drn_hold_gray", 32'(bus.wr_ptr_gray), 32'(gray5(w)));
        chk("drn_not_done", 32'(bus.drain_done), 0);
        bus.rd_ptr_gray_sync = gray5(w - 5'd2);
        tick();
        chk("drn_cnt2", 32'(bus.wr_count), 2);
        chk("drn_still", 32'(bus.drain_done), 0);
        bus.rd_ptr_gray_sync = gray5(w);
        tick();
        chk("drn_cnt0", 32'(bus.wr_count), 0);
        chk("drn_done", 32'(bus.drain_done), 1);
        chk("drn_ready_done", 32'(bus.wr_ready), 0);
        bus.wr_en = 1'b0;
        tick();
        chk("drn_done_pulse", 32'(bus.drain_done), 0);
        chk("drn_ready_back", 32'(bus.wr_ready), 1);

        // Drain request on an already empty FIFO.
        bus.drain_req = 1'b1;
        tick();
        bus.drain_req = 1'b0;
        chk("edrn_1", 32'(bus.drain_done), 0);
        tick();
        chk("edrn_2", 32'(bus.drain_done), 1);
        tick();
        chk("edrn_3", 32'(bus.drain_done), 0);

        // Asynchronous reset after 7 accepts.
        bus.wr_en = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        chk("mid_cnt7", 32'(bus.wr_count), 7);
        bus.wr_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_gray", 32'(bus.wr_ptr_gray), 0);
        chk("mid_cnt", 32'(bus.wr_count), 0);
        chk("mid_addr", 32'(bus.mem_waddr), 0);
        chk("mid_full", 32'(bus.full), 0);
        chk("mid_af", 32'(bus.almost_full), 0);
        chk("mid_ovf", 32'(bus.overflow), 0);
        bus.rd_ptr_gray_sync = '0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.wr_en = 1'b1;
        #1;
        chk("post_addr", 32'(bus.mem_waddr), 0);
        chk("post_we", 32'(bus.mem_we), 1);
        tick();
        chk("post_cnt", 32'(bus.wr_count), 1);
        chk("post_gray", 32'(bus.wr_ptr_gray), 1);
        bus.wr_en = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
